// File: rtl/uart_result_tx.sv
// rtl/uart_result_tx.sv - N-bit word to NB back-to-back 8N1 UART frames, LSB byte first; UART_TX_PARITY_EN adds even parity
module uart_result_tx #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 57600,
    parameter int N              = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic         uart_txd,
    output logic         o_busy,
    output logic         o_done
);

    localparam int DIV = clk_freq / uart_baud_rate;
    localparam int NB  = N / 8;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t         state;
    logic [CW-1:0]  baud_cnt;
    logic [2:0]     bit_cnt;
    logic [BW-1:0]  byte_idx;
    logic [7:0]     byte_q;
    logic [N-1:0]   word_q;
    logic           baud_end;
`ifdef UART_TX_PARITY_EN
    logic           parity_q;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            byte_q   <= '0;
            word_q   <= '0;
            uart_txd <= 1'b1;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (i_valid && o_ready) begin
                        // word_q holds the bytes still to be sent, next byte in its low bits
                        byte_q   <= i_data[7:0];
                        word_q   <= i_data >> 8;
                        byte_idx <= '0;
                        state    <= START;
                        uart_txd <= 1'b0;
                        o_ready  <= 1'b0;
                        o_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        parity_q <= ^i_data[7:0];
`endif
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                        uart_txd <= byte_q[0];
                        byte_q   <= byte_q >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= parity_q;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            uart_txd <= byte_q[0];
                            byte_q   <= byte_q >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        uart_txd <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 1'b1;
                            byte_q   <= word_q[7:0];
                            word_q   <= word_q >> 8;
                            state    <= START;
                            uart_txd <= 1'b0;
`ifdef UART_TX_PARITY_EN
                            parity_q <= ^word_q[7:0];
`endif
                        end else begin
                            state   <= IDLE;
                            o_ready <= 1'b1;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    o_ready  <= 1'b1;
                    o_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_result_tx.sv
// tb/tb_uart_result_tx.sv - directed bench for uart_result_tx at DIV=8, N=16; UART_TX_PARITY_EN selects 11-bit frames
module tb_uart_result_tx;

    localparam int DIV = 8;
    localparam int NB  = 2;
`ifdef UART_TX_PARITY_EN
    localparam int FB  = 11;
    localparam int LAT = 177;
`else
    localparam int FB  = 10;
    localparam int LAT = 161;
`endif
    localparam int W = NB * FB * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] i_data = 16'h0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        uart_txd;
    logic        o_busy;
    logic        o_done;

    int total = 0;
    int bad = 0;

    logic cap_txd   [0:511];
    logic cap_done  [0:511];
    logic cap_ready [0:511];

    uart_result_tx #(.clk_freq(800), .uart_baud_rate(100), .N(16)) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .uart_txd(uart_txd), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    // Receiver model: mid-bit samples of one frame starting at capture index base
    function automatic logic [10:0] rx_frame(input int base);
        logic [10:0] f = '0;
        for (int b = 0; b < FB; b++) f[b] = cap_txd[base + b * DIV + DIV / 2];
        return f;
    endfunction

    task automatic do_accept(input logic [15:0] w, input logic keep);
        int t = 0;
        @(negedge clk);
        i_data = w;
        i_valid = 1'b1;
        while (!o_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (o_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_timeout got o_ready=%b exp=1", o_ready);
        end
        @(posedge clk);
        #1;
        if (!keep) i_valid = 1'b0;
    endtask

    // cap_*[c] holds the value seen in cycle c+1 after the accept edge
    task automatic capture(input int n, input int e1_idx, input logic e1_valid,
                           input logic [15:0] e1_data, input int e2_idx, input logic e2_valid);
        for (int c = 0; c < n; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            cap_txd[c]   = uart_txd;
            cap_done[c]  = o_done;
            cap_ready[c] = o_ready;
            if (c == e1_idx) begin
                i_valid = e1_valid;
                i_data  = e1_data;
            end
            if (c == e2_idx) i_valid = e2_valid;
        end
    endtask

    task automatic test_reset;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({uart_txd, o_ready, o_busy, o_done} !== 4'b1100) begin
                bad++;
                $display("FAIL reset_hold got=%b exp=1100", {uart_txd, o_ready, o_busy, o_done});
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            total++;
            if ({uart_txd, o_ready, o_busy, o_done} !== 4'b1100) begin
                bad++;
                $display("FAIL idle_after_reset cyc=%0d got=%b exp=1100", i, {uart_txd, o_ready, o_busy, o_done});
            end
        end
    endtask

    task automatic test_single;
        logic [10:0] f0, f1;
        int first_done = -1;
        int ndone = 0;
        do_accept(16'hA53C, 1'b0);
        capture(W + 10, -1, 1'b0, 16'h0, -1, 1'b0);
        total++;
        if (cap_txd[0] !== 1'b0) begin
            bad++;
            $display("FAIL single_first_low got=%b exp=0", cap_txd[0]);
        end
        f0 = rx_frame(0);
        f1 = rx_frame(FB * DIV);
`ifdef UART_TX_PARITY_EN
        total++;
        if (f0 !== 11'h478) begin bad++; $display("FAIL single_frame0 got=%h exp=478", f0); end
        total++;
        if (f1 !== 11'h54A) begin bad++; $display("FAIL single_frame1 got=%h exp=54A", f1); end
`else
        total++;
        if (f0 !== 11'h278) begin bad++; $display("FAIL single_frame0 got=%h exp=278", f0); end
        total++;
        if (f1 !== 11'h34A) begin bad++; $display("FAIL single_frame1 got=%h exp=34A", f1); end
`endif
        for (int c = 0; c < W + 10; c++) begin
            if (cap_done[c] === 1'b1) begin
                ndone++;
                if (first_done < 0) first_done = c;
            end
        end
        total++;
        if (ndone != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", ndone); end
        total++;
        if (first_done + 1 != LAT) begin
            bad++;
            $display("FAIL single_done_latency got=%0d exp=%0d", first_done + 1, LAT);
        end
    endtask

    task automatic test_back_to_back;
        logic [10:0] f [4];
        logic [7:0] eb [4] = '{8'h01, 8'h00, 8'hFF, 8'hFF};
        do_accept(16'h0001, 1'b1);
        capture(2 * W + 10, 0, 1'b1, 16'hFFFF, W + 1, 1'b0);
        total++;
        if ({cap_done[W], cap_ready[W], cap_txd[W]} !== 3'b111) begin
            bad++;
            $display("FAIL b2b_done_cycle got=%b exp=111", {cap_done[W], cap_ready[W], cap_txd[W]});
        end
        total++;
        if ({cap_txd[W - 1], cap_txd[W], cap_txd[W + 1]} !== 3'b110) begin
            bad++;
            $display("FAIL b2b_idle_gap got=%b exp=110", {cap_txd[W - 1], cap_txd[W], cap_txd[W + 1]});
        end
        total++;
        if (cap_done[2 * W + 1] !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second_done got=%b exp=1", cap_done[2 * W + 1]);
        end
        f[0] = rx_frame(0);
        f[1] = rx_frame(FB * DIV);
        f[2] = rx_frame(W + 1);
        f[3] = rx_frame(W + 1 + FB * DIV);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (f[k] !== exp_frame(eb[k])) begin
                bad++;
                $display("FAIL b2b_byte%0d got=%h exp=%h", k, f[k], exp_frame(eb[k]));
            end
        end
    endtask

    task automatic test_busy_ignore;
        int lows = 0;
        do_accept(16'hA53C, 1'b0);
        capture(W + 40, 40, 1'b1, 16'h1234, 41, 1'b0);
        total++;
        if (rx_frame(0) !== exp_frame(8'h3C)) begin
            bad++;
            $display("FAIL busy_byte0 got=%h exp=%h", rx_frame(0), exp_frame(8'h3C));
        end
        total++;
        if (rx_frame(FB * DIV) !== exp_frame(8'hA5)) begin
            bad++;
            $display("FAIL busy_byte1 got=%h exp=%h", rx_frame(FB * DIV), exp_frame(8'hA5));
        end
        for (int c = W; c < W + 40; c++) if (cap_txd[c] !== 1'b1) lows++;
        total++;
        if (lows != 0) begin bad++; $display("FAIL busy_extra_traffic got=%0d low cycles exp=0", lows); end
        total++;
        if ({o_busy, o_ready} !== 2'b01) begin
            bad++;
            $display("FAIL busy_end_idle got=%b exp=01", {o_busy, o_ready});
        end
    endtask

    task automatic test_async_reset;
        do_accept(16'h0000, 1'b0);
        capture(36, -1, 1'b0, 16'h0, -1, 1'b0);
        total++;
        if (cap_txd[35] !== 1'b0) begin bad++; $display("FAIL arst_pre_low got=%b exp=0", cap_txd[35]); end
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({uart_txd, o_busy, o_ready} !== 3'b101) begin
            bad++;
            $display("FAIL arst_immediate got=%b exp=101", {uart_txd, o_busy, o_ready});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({uart_txd, o_done} !== 2'b10) begin
                bad++;
                $display("FAIL arst_hold got=%b exp=10", {uart_txd, o_done});
            end
        end
        rst = 1'b1;
        do_accept(16'h00FF, 1'b0);
        capture(W + 5, -1, 1'b0, 16'h0, -1, 1'b0);
        total++;
        if (rx_frame(0) !== exp_frame(8'hFF)) begin
            bad++;
            $display("FAIL arst_after_byte0 got=%h exp=%h", rx_frame(0), exp_frame(8'hFF));
        end
        total++;
        if (rx_frame(FB * DIV) !== exp_frame(8'h00)) begin
            bad++;
            $display("FAIL arst_after_byte1 got=%h exp=%h", rx_frame(FB * DIV), exp_frame(8'h00));
        end
        total++;
        if (cap_done[W] !== 1'b1) begin bad++; $display("FAIL arst_after_done got=%b exp=1", cap_done[W]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        do_accept(16'h0301, 1'b0);
        capture(W + 10, -1, 1'b0, 16'h0, -1, 1'b0);
        total++;
        if (rx_frame(0) !== 11'h602) begin bad++; $display("FAIL parity_byte01 got=%h exp=602", rx_frame(0)); end
        total++;
        if (rx_frame(FB * DIV) !== 11'h406) begin
            bad++;
            $display("FAIL parity_byte03 got=%h exp=406", rx_frame(FB * DIV));
        end
        total++;
        if (cap_done[176] !== 1'b1) begin bad++; $display("FAIL parity_done_177 got=%b exp=1", cap_done[176]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_busy_ignore();
        test_async_reset();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
